// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for apb_mem_ctrl: FSM state encoding, byte-offset width, address legality.
// Optional byte strobes are controlled by the APB_MEM_STRB_EN macro in the top and merge files.
package apb_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERR     = 3'd1,
    ST_WR      = 3'd2,
    ST_RD      = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_RMW_RD  = 3'd5,
    ST_RMW_WR  = 3'd6
  } state_t;

  localparam int PADDR_MAX = 64;

  function automatic int byte_ofs(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Illegal when any sub-word byte bit is set or any bit above the memory window is set.
  function automatic logic addr_err(input logic [PADDR_MAX-1:0] paddr,
                                    input int paddr_width,
                                    input int ofs,
                                    input int addr_width);
    logic err;
    err = 1'b0;
    for (int i = 0; i < PADDR_MAX; i++) begin
      if ((i < paddr_width) && ((i < ofs) || (i >= ofs + addr_width)) && paddr[i])
        err = 1'b1;
    end
    return err;
  endfunction

endpackage

// File: rtl/apb_mem_strb_merge.sv
// Per-byte merge of new write data over old memory data under byte strobes; purely combinational.
// Used by apb_mem_ctrl only when APB_MEM_STRB_EN is defined.
module apb_mem_strb_merge #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   merged
);

  for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_byte
    assign merged[b*8 +: 8] = strb[b] ? wdata[b*8 +: 8] : rdata[b*8 +: 8];
  end

endmodule

// File: rtl/apb_mem_ctrl.sv
// APB slave sequencing a single-port registered-read memory; reads and partial writes take one wait state.
// Byte strobes and read-modify-write are enabled by defining APB_MEM_STRB_EN.
module apb_mem_ctrl
  import apb_mem_pkg::*;
#(
  parameter int PADDR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_psel,
  input  logic                    i_penable,
  input  logic                    i_pwrite,
  input  logic [PADDR_WIDTH-1:0]  i_paddr,
  input  logic [DATA_WIDTH-1:0]   i_pwdata,
`ifdef APB_MEM_STRB_EN
  input  logic [DATA_WIDTH/8-1:0] i_pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   o_prdata,
  output logic                    o_pready,
  output logic                    o_pslverr,
  output logic                    o_mem_en,
  output logic                    o_mem_wr,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

  localparam int BYTE_OFS = byte_ofs(DATA_WIDTH);

  state_t                 state;
  state_t                 nxt;
  logic   [1:0]           rst_sync;
  logic                   rst_sync_n;
  logic                   setup;
  logic                   bad_addr;
  logic                   strb_full;
  logic                   strb_none;
  logic [ADDR_WIDTH-1:0]  word_addr;
  logic [DATA_WIDTH-1:0]  rmw_wdata;

  // Reset asserts asynchronously and releases two clocks later, so state clears immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_sync_n = rst_sync[1];

  always_ff @(posedge i_clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= ST_IDLE;
    else             state <= nxt;
  end

  assign setup     = i_psel && !i_penable;
  assign bad_addr  = addr_err(PADDR_MAX'(i_paddr), PADDR_WIDTH, BYTE_OFS, ADDR_WIDTH);
  assign word_addr = i_paddr[BYTE_OFS +: ADDR_WIDTH];

`ifdef APB_MEM_STRB_EN
  assign strb_full = &i_pstrb;
  assign strb_none = ~|i_pstrb;

  apb_mem_strb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_strb_merge (
    .wdata  (i_pwdata),
    .rdata  (i_mem_rdata),
    .strb   (i_pstrb),
    .merged (rmw_wdata)
  );
`else
  assign strb_full = 1'b1;
  assign strb_none = 1'b0;
  assign rmw_wdata = i_pwdata;
`endif

  always_comb begin
    nxt         = state;
    o_prdata    = '0;
    o_pready    = 1'b0;
    o_pslverr   = 1'b0;
    o_mem_en    = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (state == ST_IDLE) begin
      if (setup) begin
        if (bad_addr)                    nxt = ST_ERR;
        else if (!i_pwrite)              nxt = ST_RD;
        else if (strb_full || strb_none) nxt = ST_WR;
`ifdef APB_MEM_STRB_EN
        else                             nxt = ST_RMW_RD;
`endif
      end
    end else if (!i_psel) begin
      nxt = ST_IDLE;
    end else begin
      case (state)
        ST_ERR: begin
          o_pready  = 1'b1;
          o_pslverr = 1'b1;
          nxt       = ST_IDLE;
        end
        ST_WR: begin
          // A zero-strobe write completes without touching memory.
          o_pready = 1'b1;
          if (!strb_none) begin
            o_mem_en    = 1'b1;
            o_mem_wr    = 1'b1;
            o_mem_addr  = word_addr;
            o_mem_wdata = i_pwdata;
          end
          nxt = ST_IDLE;
        end
        ST_RD: begin
          o_mem_en   = 1'b1;
          o_mem_addr = word_addr;
          nxt        = ST_RD_RESP;
        end
        ST_RD_RESP: begin
          o_pready = 1'b1;
          o_prdata = i_mem_rdata;
          nxt      = ST_IDLE;
        end
`ifdef APB_MEM_STRB_EN
        ST_RMW_RD: begin
          o_mem_en   = 1'b1;
          o_mem_addr = word_addr;
          nxt        = ST_RMW_WR;
        end
        ST_RMW_WR: begin
          o_pready    = 1'b1;
          o_mem_en    = 1'b1;
          o_mem_wr    = 1'b1;
          o_mem_addr  = word_addr;
          o_mem_wdata = rmw_wdata;
          nxt         = ST_IDLE;
        end
`endif
        default: nxt = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// Directed bench for apb_mem_ctrl with a registered-read memory model; strobe scenarios run when
// APB_MEM_STRB_EN is defined.
module tb_apb_mem_ctrl;

  localparam int PW = 32;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [PW-1:0] paddr;
  logic [DW-1:0] pwdata;
`ifdef APB_MEM_STRB_EN
  logic [1:0]    pstrb;
`endif
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;

`ifdef APB_MEM_STRB_EN
  localparam logic [DW-1:0] EXP_WORD = 16'hBE12;
`else
  localparam logic [DW-1:0] EXP_WORD = 16'hBEEF;
`endif

  // results of the most recent xfer call
  logic [DW-1:0] r_rdata;
  logic          r_err;
  int            r_waits;
  logic          r_f_en;
  logic          r_f_wr;
  logic [AW-1:0] r_f_addr;
  logic [DW-1:0] r_f_wdata;
  logic          r_any_en;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  apb_mem_ctrl #(
    .PADDR_WIDTH (PW),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_psel      (psel),
    .i_penable   (penable),
    .i_pwrite    (pwrite),
    .i_paddr     (paddr),
    .i_pwdata    (pwdata),
`ifdef APB_MEM_STRB_EN
    .i_pstrb     (pstrb),
`endif
    .o_prdata    (prdata),
    .o_pready    (pready),
    .o_pslverr   (pslverr),
    .o_mem_en    (mem_en),
    .o_mem_wr    (mem_wr),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) begin
        mem[mem_addr] <= mem_wdata;
        wr_count <= wr_count + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic drive_setup(input logic wr, input logic [PW-1:0] addr,
                             input logic [DW-1:0] data, input logic [1:0] strb);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
`ifdef APB_MEM_STRB_EN
    pstrb   = strb;
`else
    if (strb != 2'b11) $display("note: strobes 0x%0h ignored in full-word build", strb);
`endif
  endtask

  task automatic xfer(input logic wr, input logic [PW-1:0] addr,
                      input logic [DW-1:0] data, input logic [1:0] strb);
    bit done;
    @(posedge clk); #1;
    drive_setup(wr, addr, data, strb);
    @(negedge clk);
    r_any_en = mem_en;
    @(posedge clk); #1;
    penable = 1'b1;
    r_waits = 0;
    r_rdata = '0;
    r_err   = 1'b0;
    done    = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        r_f_en    = mem_en;
        r_f_wr    = mem_wr;
        r_f_addr  = mem_addr;
        r_f_wdata = mem_wdata;
      end
      r_any_en = r_any_en | mem_en;
      if (pready) begin
        done    = 1'b1;
        r_rdata = prdata;
        r_err   = pslverr;
      end else begin
        r_waits++;
      end
    end
    if (!done) r_waits = 99;
  endtask

  task automatic bus_idle();
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
`ifdef APB_MEM_STRB_EN
    pstrb = 2'b11;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({prdata, pready, pslverr, mem_en, mem_wr, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got prdata=%h rdy=%b err=%b en=%b wr=%b addr=%h wdata=%h, need all 0",
               prdata, pready, pslverr, mem_en, mem_wr, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    // enter RD, then assert reset mid-cycle
    #1 drive_setup(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    @(posedge clk); #1 penable = 1'b1;
    #2;
    checks++;
    if (mem_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_rd_en: got %b need 1", mem_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({prdata, pready, pslverr, mem_en, mem_wr, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_midcycle: got en=%b wr=%b addr=%h rdy=%b, need all 0",
               mem_en, mem_wr, mem_addr, pready);
    end
    bus_idle();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pready, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle: got rdy=%b en=%b need 0 0", pready, mem_en);
    end
  endtask

  task automatic test_write_read();
    xfer(1'b1, 32'h0000_0010, 16'hBEEF, 2'b11);
    checks++;
    if ({r_waits == 0, r_f_en, r_f_wr, r_err} !== 4'b1110) begin
      errors++;
      $display("FAIL wr_timing: got waits=%0d en=%b wr=%b err=%b need 0 1 1 0", r_waits, r_f_en, r_f_wr, r_err);
    end
    checks++;
    if ({r_f_addr, r_f_wdata} !== {16'h0008, 16'hBEEF}) begin
      errors++;
      $display("FAIL wr_addr_data: got addr=%h wdata=%h need 0008 beef", r_f_addr, r_f_wdata);
    end
    xfer(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    checks++;
    if (r_waits != 1 || r_f_en !== 1'b1 || r_f_wr !== 1'b0 || r_f_addr !== 16'h0008) begin
      errors++;
      $display("FAIL rd_timing: got waits=%0d en=%b wr=%b addr=%h need 1 1 0 0008", r_waits, r_f_en, r_f_wr, r_f_addr);
    end
    checks++;
    if (r_rdata !== 16'hBEEF || r_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_data: got %h err=%b need beef 0", r_rdata, r_err);
    end
    bus_idle();
  endtask

`ifdef APB_MEM_STRB_EN
  task automatic test_strb();
    xfer(1'b1, 32'h0000_0010, 16'h0012, 2'b01);
    checks++;
    if (r_waits != 1 || r_err !== 1'b0) begin
      errors++;
      $display("FAIL rmw_timing: got waits=%0d err=%b need 1 0", r_waits, r_err);
    end
    checks++;
    if (mem[16'h0008] !== 16'hBE12) begin
      errors++;
      $display("FAIL rmw_mem: got %h need be12", mem[16'h0008]);
    end
    xfer(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    checks++;
    if (r_rdata !== 16'hBE12) begin
      errors++;
      $display("FAIL rmw_readback: got %h need be12", r_rdata);
    end
    xfer(1'b1, 32'h0000_0010, 16'hFFFF, 2'b00);
    checks++;
    if (r_waits != 0 || r_any_en !== 1'b0) begin
      errors++;
      $display("FAIL zero_strb: got waits=%0d any_en=%b need 0 0", r_waits, r_any_en);
    end
    xfer(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    checks++;
    if (r_rdata !== 16'hBE12) begin
      errors++;
      $display("FAIL zero_strb_readback: got %h need be12", r_rdata);
    end
    bus_idle();
  endtask

  task automatic test_reset_rmw();
    int wc;
    @(posedge clk); #1 drive_setup(1'b1, 32'h0000_0010, 16'h0055, 2'b01);
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_wr} !== 2'b10) begin
      errors++;
      $display("FAIL rmw_rd_phase: got en=%b wr=%b need 1 0", mem_en, mem_wr);
    end
    wc = wr_count;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rmw_reset_en: got %b need 0", mem_en);
    end
    bus_idle();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    checks++;
    if (wr_count != wc) begin
      errors++;
      $display("FAIL rmw_reset_nowrite: got %0d writes need %0d", wr_count, wc);
    end
    xfer(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    checks++;
    if (r_rdata !== 16'hBE12) begin
      errors++;
      $display("FAIL rmw_reset_readback: got %h need be12", r_rdata);
    end
    bus_idle();
  endtask
`endif

  task automatic test_error();
    logic [PW-1:0] bad [2];
    bad[0] = 32'h0000_0011;
    bad[1] = 32'h0002_0000;
    for (int i = 0; i < 2; i++) begin
      xfer(i[0], bad[i], 16'hA5A5, 2'b11);
      checks++;
      if (r_err !== 1'b1 || r_waits != 0 || r_any_en !== 1'b0 || r_rdata !== 16'h0) begin
        errors++;
        $display("FAIL err_addr_%0d: got err=%b waits=%0d any_en=%b rdata=%h need 1 0 0 0000",
                 i, r_err, r_waits, r_any_en, r_rdata);
      end
    end
    bus_idle();
  endtask

  task automatic test_abort();
    @(posedge clk); #1 drive_setup(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    @(posedge clk); #1 psel = 1'b0;
    @(negedge clk);
    checks++;
    if ({pready, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL abort_rd: got rdy=%b en=%b need 0 0", pready, mem_en);
    end
    xfer(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    checks++;
    if (r_waits != 1 || r_rdata !== EXP_WORD) begin
      errors++;
      $display("FAIL abort_readback: got waits=%0d data=%h need 1 %h", r_waits, r_rdata, EXP_WORD);
    end
    bus_idle();
  endtask

  task automatic test_back_to_back();
    xfer(1'b1, 32'h0000_0100, 16'h1234, 2'b11);
    checks++;
    if (r_waits != 0 || r_f_addr !== 16'h0080) begin
      errors++;
      $display("FAIL b2b_wr: got waits=%0d addr=%h need 0 0080", r_waits, r_f_addr);
    end
    xfer(1'b0, 32'h0000_0100, 16'h0, 2'b11);
    checks++;
    if (r_waits != 1 || r_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL b2b_rd: got waits=%0d data=%h need 1 1234", r_waits, r_rdata);
    end
    xfer(1'b0, 32'h0000_0010, 16'h0, 2'b11);
    checks++;
    if (r_waits != 1 || r_rdata !== EXP_WORD) begin
      errors++;
      $display("FAIL b2b_rd2: got waits=%0d data=%h need 1 %h", r_waits, r_rdata, EXP_WORD);
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
`ifdef APB_MEM_STRB_EN
    test_strb();
`endif
    test_error();
`ifdef APB_MEM_STRB_EN
    test_reset_rmw();
`endif
    test_abort();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mem_ctrl.md
# apb_mem_ctrl

APB slave controller that sequences a single-port synchronous memory (one access per cycle, registered read data) on behalf of one APB requester. It decodes APB setup/access phases into memory enable/write strobes, inserts the wait state needed for registered reads, performs read-modify-write for byte-strobed writes, and flags illegal addresses with PSLVERR. It sits between the APB interconnect and the memory model in the APB controller subsystem.

## Interface

- PADDR_WIDTH, 32, APB byte-address width
- ADDR_WIDTH, 16, memory word-address width (depth 2^ADDR_WIDTH)
- DATA_WIDTH, 16, APB and memory data width; multiple of 8, at least 16
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_psel  input  1  APB select
- i_penable  input  1  APB enable (access phase)
- i_pwrite  input  1  1 write, 0 read
- i_paddr  input  PADDR_WIDTH  byte address
- i_pwdata  input  DATA_WIDTH  write data
- i_pstrb  input  DATA_WIDTH/8  byte strobes (present only with APB_MEM_STRB_EN)
- o_prdata  output  DATA_WIDTH  read data
- o_pready  output  1  transfer complete
- o_pslverr  output  1  transfer error
- o_mem_en  output  1  memory enable
- o_mem_wr  output  1  memory write (1) / read (0)
- o_mem_addr  output  ADDR_WIDTH  memory word address
- o_mem_wdata  output  DATA_WIDTH  memory write data
- i_mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after a read enable

## Operation

- BYTE_OFS = $clog2(DATA_WIDTH/8); o_mem_addr = i_paddr[BYTE_OFS +: ADDR_WIDTH].
- Error address: any of i_paddr[BYTE_OFS-1:0] nonzero (misaligned) or any bit at or above BYTE_OFS+ADDR_WIDTH set.
- States: IDLE, ERR, WR, RD, RD_RESP, RMW_RD, RMW_WR. State is the only register apart from the reset logic; all outputs decode from state plus live APB inputs.
- IDLE: on i_psel && !i_penable (setup) choose: error -> ERR; read -> RD; write with full strobes -> WR; write with partial nonzero strobes -> RMW_RD; write with zero strobes -> WR with no memory access. i_penable high in IDLE without a prior setup is ignored.
- ERR: o_pready=1, o_pslverr=1, no memory access -> IDLE.
- WR: o_mem_en=1, o_mem_wr=1, o_mem_wdata=i_pwdata, o_pready=1 -> IDLE.
- RD: o_mem_en=1, o_mem_wr=0, o_pready=0 -> RD_RESP.
- RD_RESP: o_pready=1, o_prdata=i_mem_rdata -> IDLE.
- RMW_RD: as RD -> RMW_WR.
- RMW_WR: o_mem_en=1, o_mem_wr=1, o_mem_wdata = per-byte i_pstrb ? i_pwdata : i_mem_rdata, o_pready=1 -> IDLE.
- i_psel low in any non-IDLE state: abort to IDLE, no memory access in that cycle, o_pready=0.
- o_prdata is 0 outside RD_RESP; o_pslverr is 0 outside ERR; o_mem_* are 0 when o_mem_en=0.

## Timing

- Reset (async assert, sync release): state IDLE; o_prdata, o_pready, o_pslverr, o_mem_en, o_mem_wr, o_mem_addr, o_mem_wdata all 0.
- Full write and error: zero wait states (complete in first access cycle).
- Read and partial write: one wait state (complete in second access cycle).
- Back-to-back: a new setup in the cycle after completion is accepted from IDLE; no idle cycle inserted by the block.
- Reset during RD, RMW_RD, or RMW_WR: memory enable drops immediately; no write is issued after reset assertion.

## Configuration

- APB_MEM_STRB_EN defined: i_pstrb port present; RMW_RD/RMW_WR reachable; zero-strobe writes complete without memory access.
- Undefined: no i_pstrb port; every write is a full-word write through WR; RMW states not synthesized.

## Structure

- Package apb_mem_pkg: state enum typedef, BYTE_OFS computation function, error-address check function.
- Sub-module apb_mem_strb_merge: combinational per-byte merge of write data and read data under strobes; instantiated only with APB_MEM_STRB_EN.

## Test plan

- Reset: i_rst_n=0 mid-cycle -> all outputs 0 immediately, state IDLE after release.
- Write 0xBEEF to paddr 0x0010 -> first access cycle o_pready=1, o_mem_en=1, o_mem_wr=1, o_mem_addr=0x0008, o_mem_wdata=0xBEEF; read 0x0010 -> o_pready=1 in second access cycle, o_prdata=0xBEEF.
- (STRB_EN) Write 0x0012, i_pstrb=2'b01 to word holding 0xBEEF -> one wait state, memory written 0xBE12; readback 0xBE12.
- paddr 0x0011 and paddr 0x0002_0000 -> o_pslverr=1, o_pready=1 in first access cycle, o_mem_en never asserted.
- i_rst_n=0 during RMW_RD of a partial write to 0x0010 -> no write issued; readback after reset 0xBE12.
- i_psel deasserted during RD -> IDLE, o_pready=0; following read of 0x0010 returns 0xBE12 with one wait state.
